// File: rtl/ahb_switch_slave_port.sv
// Slave-side port of the AHB3-Lite multi-layer switch: arbitrates master-port requests
// and drives the winner onto the slave bus. Define AHB_SWITCH_ROUND_ROBIN_EN for round-robin ties.
module ahb_switch_slave_port #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int MASTERS    = 3
) (
   input  logic                    HCLK,
   input  logic                    HRESET,

   input  logic [2:0]              mstpriority  [MASTERS],
   input  logic [MASTERS-1:0]      mstHSEL,
   input  logic [HADDR_SIZE-1:0]   mstHADDR     [MASTERS],
   input  logic [HDATA_SIZE-1:0]   mstHWDATA    [MASTERS],
   input  logic [MASTERS-1:0]      mstHWRITE,
   input  logic [2:0]              mstHSIZE     [MASTERS],
   input  logic [2:0]              mstHBURST    [MASTERS],
   input  logic [3:0]              mstHPROT     [MASTERS],
   input  logic [1:0]              mstHTRANS    [MASTERS],
   input  logic [MASTERS-1:0]      mstHMASTLOCK,
   input  logic [MASTERS-1:0]      mstHREADY,
   input  logic [MASTERS-1:0]      can_switch,

   output logic [MASTERS-1:0]      master_granted,
   output logic [HDATA_SIZE-1:0]   mstHRDATA,
   output logic [MASTERS-1:0]      mstHREADYOUT,
   output logic [MASTERS-1:0]      mstHRESP,

   output logic                    HSEL,
   output logic [HADDR_SIZE-1:0]   HADDR,
   output logic [HDATA_SIZE-1:0]   HWDATA,
   output logic                    HWRITE,
   output logic [2:0]              HSIZE,
   output logic [2:0]              HBURST,
   output logic [3:0]              HPROT,
   output logic [1:0]              HTRANS,
   output logic                    HMASTLOCK,
   output logic                    HREADY,
   input  logic [HDATA_SIZE-1:0]   HRDATA,
   input  logic                    HREADYOUT,
   input  logic                    HRESP
);

   localparam int         IDX_W       = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   logic [MASTERS-1:0]    data_owner;
   logic [MASTERS-1:0]    winner_onehot;
   logic [IDX_W-1:0]      winner_idx;
   logic [2:0]            best_pri;
   logic                  found;
   logic                  grant_ok;

   logic                  own_sel, own_cs, own_lock, own_write;
   logic [HADDR_SIZE-1:0] own_addr;
   logic [2:0]            own_size, own_burst;
   logic [3:0]            own_prot;
   logic [1:0]            own_trans;

   // The master-side HREADY is not needed: this port is the only master on its bus.
   logic                  unused_mst_hready;
   assign unused_mst_hready = ^mstHREADY;

`ifdef AHB_SWITCH_ROUND_ROBIN_EN
   logic [IDX_W-1:0]      rr_ptr;
   int                    idx;

   // Scan from rr_ptr; strict '>' keeps the first hit in scan order on ties.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      found      = 1'b0;
      best_pri   = '0;
      winner_idx = '0;
      idx        = 0;
      for (int k = 0; k < MASTERS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= MASTERS) idx = idx - MASTERS;
         if (mstHSEL[idx] && (!found || mstpriority[idx] > best_pri)) begin
            found      = 1'b1;
            best_pri   = mstpriority[idx];
            winner_idx = IDX_W'(idx);
         end
      end
   end
`else
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      found      = 1'b0;
      best_pri   = '0;
      winner_idx = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (mstHSEL[i] && (!found || mstpriority[i] > best_pri)) begin
            found      = 1'b1;
            best_pri   = mstpriority[i];
            winner_idx = IDX_W'(i);
         end
      end
   end
`endif

   assign winner_onehot = found ? (MASTERS'(1) << winner_idx) : '0;

   always_comb begin
      own_sel   = 1'b0;
      own_cs    = 1'b0;
      own_lock  = 1'b0;
      own_write = 1'b0;
      own_addr  = '0;
      own_size  = '0;
      own_burst = '0;
      own_prot  = '0;
      own_trans = HTRANS_IDLE;
      for (int i = 0; i < MASTERS; i++) begin
         if (master_granted[i]) begin
            own_sel   = mstHSEL[i];
            own_cs    = can_switch[i];
            own_lock  = mstHMASTLOCK[i];
            own_write = mstHWRITE[i];
            own_addr  = mstHADDR[i];
            own_size  = mstHSIZE[i];
            own_burst = mstHBURST[i];
            own_prot  = mstHPROT[i];
            own_trans = mstHTRANS[i];
         end
      end
   end

   // A locked owner that still requests keeps the bus regardless of can_switch.
   assign grant_ok = HREADYOUT
                   && (~|master_granted || own_cs || !own_sel)
                   && !(own_lock && own_sel);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         master_granted <= '0;
         data_owner     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         if (grant_ok && found) master_granted <= winner_onehot;
         if (HREADYOUT)
            data_owner <= (HSEL && HTRANS != HTRANS_IDLE) ? master_granted : '0;
      end
   end

`ifdef AHB_SWITCH_ROUND_ROBIN_EN
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         rr_ptr <= '0;
      end else if (grant_ok && found && winner_onehot != master_granted) begin
         rr_ptr <= (winner_idx == IDX_W'(MASTERS - 1)) ? '0 : winner_idx + 1'b1;
      end
   end
`endif

   assign HSEL      = |master_granted & own_sel;
   assign HADDR     = own_addr;
   assign HWRITE    = own_write;
   assign HSIZE     = own_size;
   assign HBURST    = own_burst;
   assign HPROT     = own_prot;
   assign HTRANS    = HSEL ? own_trans : HTRANS_IDLE;
   assign HMASTLOCK = own_lock;
   assign HREADY    = HREADYOUT;

   always_comb begin
      HWDATA = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (data_owner[i]) HWDATA = HWDATA | mstHWDATA[i];
      end
   end

   assign mstHRDATA    = HRDATA;
   assign mstHREADYOUT = ~data_owner | {MASTERS{HREADYOUT}};
   assign mstHRESP     = data_owner & {MASTERS{HRESP}};

`ifndef SYNTHESIS
   assert property (@(posedge HCLK) disable iff (HRESET) $onehot0(master_granted));
   assert property (@(posedge HCLK) disable iff (HRESET) $onehot0(data_owner));
`endif

endmodule
